// File: rtl/spi_slave_rx_tx.sv
// spi_slave_rx_tx: mode-0 SPI slave with oversampled inputs, rx holding register and single-entry tx buffer.
// Define SPI_SLAVE_OVERRUN_EN to drop words that arrive while rx_valid is pending and raise overrun.
module spi_slave_rx_tx #(
  parameter int DATA_W      = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              sclk,
  input  logic              ss,
  input  logic              mosi,
  output logic              miso,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_load,
  output logic              tx_ready,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  input  logic              rx_ack,
  output logic              busy,
  output logic              overrun
);
  localparam int CW = $clog2(DATA_W + 1);
  typedef enum logic {IDLE, ACTIVE} state_t;
  state_t state, state_nx;
  logic [SYNC_STAGES-1:0] sclk_sync, ss_sync, mosi_sync, fill;
  logic [DATA_W-1:0] tx_shift, tx_buf, load_val;
  logic [DATA_W-2:0] rx_shift;
  logic [CW-1:0] bit_cnt;
  logic sclk_d, ss_d, armed, tx_full;
  logic sclk_s, ss_s, mosi_s, ss_fall, ss_rise;
  logic start, stop, rise, fall, done, take, consume, accept;
  assign sclk_s   = sclk_sync[SYNC_STAGES-1];
  assign ss_s     = ss_sync[SYNC_STAGES-1];
  assign mosi_s   = mosi_sync[SYNC_STAGES-1];
  // armed only once a genuinely sampled high ss has reached the sync output
  assign ss_fall  = armed & ss_d & ~ss_s;
  assign ss_rise  = ~ss_d & ss_s;
  assign start    = (state == IDLE) & ss_fall;
  assign stop     = (state == ACTIVE) & ss_rise;
  assign rise     = (state == ACTIVE) & ~ss_rise & sclk_s & ~sclk_d;
  assign fall     = (state == ACTIVE) & ~ss_rise & ~sclk_s & sclk_d;
  assign done     = rise & (bit_cnt == CW'(DATA_W - 1));
  assign consume  = start | (fall & (bit_cnt == '0));
  assign load_val = tx_full ? tx_buf : '0;
  assign accept   = tx_load & (~tx_full | consume);
  assign miso     = tx_shift[DATA_W-1];
  assign tx_ready = ~tx_full;
  assign busy     = (state == ACTIVE);
  always_comb state_nx = start ? ACTIVE : stop ? IDLE : state;
  always_ff @(posedge clk or negedge reset)
    if (!reset) state <= IDLE;
    else state <= state_nx;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sclk_sync <= '0;
      ss_sync   <= '1;
      mosi_sync <= '0;
      fill      <= '0;
      sclk_d    <= 1'b0;
      ss_d      <= 1'b1;
      armed     <= 1'b0;
      tx_shift  <= '0;
      tx_buf    <= '0;
      tx_full   <= 1'b0;
      bit_cnt   <= '0;
      rx_shift  <= '0;
      rx_data   <= '0;
      rx_valid  <= 1'b0;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk};
      ss_sync   <= {ss_sync[SYNC_STAGES-2:0], ss};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi};
      fill      <= {fill[SYNC_STAGES-2:0], 1'b1};
      sclk_d    <= sclk_s;
      ss_d      <= ss_s;
      armed     <= armed | (fill[SYNC_STAGES-1] & ss_s);
      tx_shift  <= consume ? load_val : fall ? tx_shift << 1 : stop ? '0 : tx_shift;
      tx_full   <= accept | (tx_full & ~consume);
      if (accept) tx_buf <= tx_data;
      bit_cnt   <= (start | stop | done) ? '0 : rise ? bit_cnt + CW'(1) : bit_cnt;
      if (rise) rx_shift <= {rx_shift[DATA_W-3:0], mosi_s};
      if (take) rx_data <= {rx_shift, mosi_s};
      rx_valid  <= take | (rx_valid & ~rx_ack);
    end
  end
`ifdef SPI_SLAVE_OVERRUN_EN
  assign take = done & (~rx_valid | rx_ack);
  always_ff @(posedge clk or negedge reset)
    if (!reset) overrun <= 1'b0;
    else overrun <= (done & ~take) | (overrun & ~rx_ack);
`else
  assign take    = done;
  assign overrun = 1'b0;
`endif
endmodule

// File: tb/tb_spi_slave_rx_tx.sv
// tb_spi_slave_rx_tx: directed SPI master stimulus against a word-level model of the slave.
module tb_spi_slave_rx_tx;
  logic clk = 1'b0, reset = 1'b0, sclk = 1'b0, ss = 1'b1, mosi = 1'b0;
  logic tx_load = 1'b0, rx_ack = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic miso, tx_ready, rx_valid, busy, overrun;
  logic [7:0] rx_data;
  int total = 0, bad = 0;
  bit chk = 1'b0;
  logic [7:0] m_rx_data, m_buf, m_acc;
  bit m_rx_valid, m_ovr, m_busy, m_full;
  int m_nbits;
  logic [7:0] txq[$];
  logic [7:0] g, g2;
`ifdef SPI_SLAVE_OVERRUN_EN
  localparam bit OVR = 1'b1;
`else
  localparam bit OVR = 1'b0;
`endif
  always #5 clk = ~clk;
  spi_slave_rx_tx dut (
    .clk(clk), .reset(reset), .sclk(sclk), .ss(ss), .mosi(mosi), .miso(miso),
    .tx_data(tx_data), .tx_load(tx_load), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ack(rx_ack),
    .busy(busy), .overrun(overrun)
  );
  task automatic cmp(input string n, input logic [31:0] a, input logic [31:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s got=%h want=%h at %0t", n, a, e, $time);
    end
  endtask
  always @(negedge clk)
    if (chk) begin
      cmp("rx_data", 32'(rx_data), 32'(m_rx_data));
      cmp("rx_valid", 32'(rx_valid), 32'(m_rx_valid));
      cmp("tx_ready", 32'(tx_ready), 32'(!m_full));
      cmp("busy", 32'(busy), 32'(m_busy));
      cmp("overrun", 32'(overrun), 32'(m_ovr));
      if (!m_busy) cmp("miso_idle", 32'(miso), 32'd0);
    end
  task automatic m_reset();
    m_rx_data = 8'h00; m_buf = 8'h00; m_acc = 8'h00;
    m_rx_valid = 0; m_ovr = 0; m_busy = 0; m_full = 0; m_nbits = 0;
    txq.delete();
  endtask
  task automatic m_consume();
    txq.push_back(m_full ? m_buf : 8'h00);
    m_full = 0;
  endtask
  task automatic m_rise(input logic b);
    m_acc = {m_acc[6:0], b};
    m_nbits++;
    if (m_nbits == 8) begin
      m_nbits = 0;
      if (OVR && m_rx_valid) m_ovr = 1;
      else begin m_rx_data = m_acc; m_rx_valid = 1; end
    end
  endtask
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic ss_lo();
    chk = 0; ss = 1'b0; step(4);
    m_busy = 1; m_nbits = 0; m_acc = 8'h00; m_consume();
    chk = 1; step(2);
  endtask
  task automatic ss_hi();
    chk = 0; ss = 1'b1; step(4);
    m_busy = 0; m_nbits = 0; txq.delete();
    chk = 1; step(2);
  endtask
  task automatic load(input logic [7:0] b);
    tx_data = b; tx_load = 1'b1; step(1); tx_load = 1'b0;
    if (!m_full) begin m_buf = b; m_full = 1; end
  endtask
  task automatic ack();
    rx_ack = 1'b1; step(1); rx_ack = 1'b0;
    m_rx_valid = 0; m_ovr = 0;
  endtask
  task automatic word(input logic [7:0] v, input int n, output logic [7:0] got);
    got = 8'h00;
    for (int i = 0; i < n; i++) begin
      mosi = v[7-i]; step(2);
      got = {got[6:0], miso};
      chk = 0; sclk = 1'b1; step(4); m_rise(v[7-i]); chk = 1; step(2);
      chk = 0; sclk = 1'b0; step(4); if (m_nbits == 0) m_consume(); chk = 1; step(2);
    end
  endtask
  task automatic xfer(input logic [7:0] v, output logic [7:0] got);
    logic [7:0] e;
    e = txq.pop_front();
    word(v, 8, got);
    cmp("miso_word", 32'(got), 32'(e));
  endtask
  initial begin
    m_reset();
    step(3);
    cmp("rst_miso", 32'(miso), 32'd0);
    cmp("rst_tx_ready", 32'(tx_ready), 32'd1);
    cmp("rst_rx_data", 32'(rx_data), 32'd0);
    cmp("rst_rx_valid", 32'(rx_valid), 32'd0);
    cmp("rst_busy", 32'(busy), 32'd0);
    cmp("rst_overrun", 32'(overrun), 32'd0);
    reset = 1'b1; chk = 1; step(4);
    // basic exchange
    load(8'hA5);
    cmp("basic_tx_ready_full", 32'(tx_ready), 32'd0);
    ss_lo(); xfer(8'h3C, g); ss_hi();
    cmp("basic_master_rx", 32'(g), 32'hA5);
    cmp("basic_rx_data", 32'(rx_data), 32'h3C);
    cmp("basic_rx_valid", 32'(rx_valid), 32'd1);
    cmp("basic_tx_ready", 32'(tx_ready), 32'd1);
    ack();
    // empty buffer
    ss_lo(); xfer(8'hFF, g); ss_hi();
    cmp("empty_master_rx", 32'(g), 32'h00);
    cmp("empty_rx_data", 32'(rx_data), 32'hFF);
    ack();
    // back-to-back words under one ss
    load(8'h81); ss_lo(); load(8'h7E);
    xfer(8'h12, g);
    cmp("b2b_rx0", 32'(rx_data), 32'h12);
    ack();
    xfer(8'h34, g2);
    cmp("b2b_rx1", 32'(rx_data), 32'h34);
    cmp("b2b_valid1", 32'(rx_valid), 32'd1);
    ack(); ss_hi();
    cmp("b2b_master0", 32'(g), 32'h81);
    cmp("b2b_master1", 32'(g2), 32'h7E);
    // abort after 5 bits
    ss_lo(); word(8'hF0, 5, g); ss_hi();
    cmp("abort_valid", 32'(rx_valid), 32'd0);
    cmp("abort_busy", 32'(busy), 32'd0);
    cmp("abort_miso", 32'(miso), 32'd0);
    ss_lo(); xfer(8'h99, g); ss_hi();
    cmp("abort_next_rx", 32'(rx_data), 32'h99);
    ack();
    // overrun
    ss_lo(); xfer(8'h11, g); ss_hi();
    ss_lo(); xfer(8'h22, g); ss_hi();
`ifdef SPI_SLAVE_OVERRUN_EN
    cmp("ovr_rx_data", 32'(rx_data), 32'h11);
    cmp("ovr_flag", 32'(overrun), 32'd1);
`else
    cmp("ovr_rx_data", 32'(rx_data), 32'h22);
    cmp("ovr_flag", 32'(overrun), 32'd0);
`endif
    ack();
    cmp("ovr_ack_valid", 32'(rx_valid), 32'd0);
    cmp("ovr_ack_flag", 32'(overrun), 32'd0);
    // reset mid-byte with pending rx word and a full tx buffer
    ss_lo(); xfer(8'h44, g); ss_hi();
    ss_lo(); load(8'hC3); word(8'h0F, 3, g);
    chk = 0; sclk = 1'b1; step(2);
    reset = 1'b0; #1;
    cmp("mid_rst_miso", 32'(miso), 32'd0);
    cmp("mid_rst_tx_ready", 32'(tx_ready), 32'd1);
    cmp("mid_rst_rx_data", 32'(rx_data), 32'd0);
    cmp("mid_rst_rx_valid", 32'(rx_valid), 32'd0);
    cmp("mid_rst_busy", 32'(busy), 32'd0);
    cmp("mid_rst_overrun", 32'(overrun), 32'd0);
    m_reset();
    sclk = 1'b0; mosi = 1'b0; step(2);
    chk = 1; reset = 1'b1; step(10);
    cmp("rst_wait_busy", 32'(busy), 32'd0);
    ss_hi(); load(8'h6B);
    ss_lo(); xfer(8'h5A, g); ss_hi();
    cmp("post_rst_rx", 32'(rx_data), 32'h5A);
    cmp("post_rst_master", 32'(g), 32'h6B);
    ack(); step(4);
    chk = 0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/spi_slave_rx_tx.md
# spi_slave_rx_tx

Mode-0 SPI slave, paired with `spi_master` on the same link and directly downstream of it. It consumes the master's `sclk`, `ss` and `mosi`, and returns `miso`. All SPI inputs are oversampled and synchronized into the system clock `clk`. Each received byte is delivered on a valid/ack holding register, and the next transmit byte comes from a single-entry buffer loaded by local logic.

## Interface
- `DATA_W`, 8 — bits per SPI word; shifted MSB first.
- `SYNC_STAGES`, 2 — synchronizer depth on `sclk`, `ss` and `mosi`; minimum 2.

- `clk`  input  1  system clock; all state is in this domain.
- `reset`  input  1  asynchronous, active-low reset.
- `sclk`  input  1  SPI clock from the master, asynchronous; idles low.
- `ss`  input  1  slave select, active low, asynchronous.
- `mosi`  input  1  master-out data, asynchronous.
- `miso`  output  1  slave-out data, registered; driven 0 while deselected.
- `tx_data`  input  DATA_W  next byte to transmit.
- `tx_load`  input  1  writes `tx_data` into the tx buffer when `tx_ready`=1.
- `tx_ready`  output  1  tx buffer empty.
- `rx_data`  output  DATA_W  last received byte.
- `rx_valid`  output  1  `rx_data` holds an unacknowledged byte.
- `rx_ack`  input  1  clears `rx_valid`.
- `busy`  output  1  high while in ACTIVE.
- `overrun`  output  1  sticky overrun flag; tied 0 without the macro.

## Operation
- **Synchronizers:** the `ss` synchronizer resets to 1; the `sclk` and `mosi` synchronizers reset to 0.
- **Edge detection:** edges are found by comparing the synchronized value with a one-cycle-delayed copy. Only the synchronized values are used from here on.
- **IDLE → ACTIVE** on a synchronized `ss` fall:
  - `tx_shift` ← tx buffer if full (the buffer empties, `tx_ready`←1), else ← 0.
  - `miso` ← MSB of the loaded value.
  - `bit_cnt` ← 0.
- **ACTIVE, `sclk` rise:**
  - `rx_shift` ← {`rx_shift`[DATA_W-2:0], `mosi`}, `bit_cnt`++.
  - When `bit_cnt` reaches DATA_W:
    - completed word → `rx_data`, `rx_valid`←1.
    - `bit_cnt` wraps to 0.
- **ACTIVE, `sclk` fall:**
  - If `bit_cnt`=0 (word boundary), reload `tx_shift` from the tx buffer using the same rules as IDLE entry.
  - Otherwise shift `tx_shift` left.
  - `miso` ← new MSB.
  - Back-to-back words are supported with no `ss` gap.
- **ACTIVE → IDLE** on a synchronized `ss` rise:
  - Any partial word is discarded: no `rx_valid`, `bit_cnt`←0, `miso`←0.
  - The tx buffer contents are kept.
- **tx buffer:**
  - `tx_load` with `tx_ready`=0 is ignored.
  - `tx_load` in the same cycle the buffer is consumed: the consume happens first, the new byte is then accepted, and `tx_ready` ends at 0.
- **rx handshake:**
  - `rx_ack` clears `rx_valid` the next cycle.
  - Word completion in the same cycle as `rx_ack`: the new word wins and `rx_valid` stays 1.
- **Reset values:** `miso` 0, `tx_ready` 1, `rx_data` 0, `rx_valid` 0, `busy` 0, `overrun` 0; state IDLE, `bit_cnt` 0, buffer empty.
- **Reset mid-transfer:** `reset` asserted mid-transfer aborts immediately. After release, the block waits for a fresh `ss` fall even if `ss` is already low.

## Timing
- Pin-to-action latency is SYNC_STAGES+1 `clk` edges. This applies to `sclk` edge → `rx_data`/`rx_valid` update, `sclk` fall → `miso` change, and `ss` fall → first `miso`.
- Required link timing:
  - `sclk` high and low phases ≥ SYNC_STAGES+2 `clk` periods.
  - `ss` fall to first `sclk` rise ≥ SYNC_STAGES+2 periods.
  - With SYNC_STAGES=2, the `sclk` frequency must be ≤ `clk`/8.
- `mosi` must be stable across the `sclk` rise; its sync path matches `sclk`, so no skew compensation is applied.

## Configuration
- `SPI_SLAVE_OVERRUN_EN` defined:
  - A word completing while `rx_valid`=1 with no `rx_ack` in that cycle is dropped; `rx_data` keeps the old word and `overrun`←1.
  - `overrun` stays set until the first `rx_ack`, which clears it together with `rx_valid`.
- Not defined:
  - A new word always overwrites `rx_data`.
  - `overrun` is constant 0.

## Test plan
- **Basic exchange:** preload 0xA5 via `tx_load`, master sends 0x3C → `rx_data`=0x3C with `rx_valid`=1, master receives 0xA5, `tx_ready` returns to 1 at `ss` fall.
- **Empty buffer:** no preload, master sends 0xFF → master receives 0x00, `rx_data`=0xFF.
- **Back-to-back words:** two bytes 0x12, 0x34 under one `ss` low, tx 0x81 then 0x7E loaded between bytes → master receives 0x81, 0x7E; two `rx_valid` events, each acked.
- **Abort:** `ss` deasserted after 5 bits → `rx_valid` stays 0, `busy` falls, `miso`=0; the next full transfer of 0x99 is received correctly.
- **Overrun (macro on):** 0x11 left unacked, then 0x22 sent → `rx_data`=0x11, `overrun`=1; after `rx_ack` both `rx_valid` and `overrun` are 0. With the macro off, `rx_data`=0x22 and `overrun`=0.
- **Reset:** `reset` pulsed low mid-byte → all outputs return to their reset values; the next transfer after a fresh `ss` fall is received correctly.
